// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator: pixel strobe, position, syncs, data-enable
// Define VTG_FRAME_CNT_EN to add the 16-bit frameCnt output.
module video_timing_gen #(
  parameter int X_MAX   = 1280,
  parameter int H_FP    = 110,
  parameter int H_SYNC  = 40,
  parameter int H_BP    = 220,
  parameter int Y_MAX   = 720,
  parameter int V_FP    = 5,
  parameter int V_SYNC  = 5,
  parameter int V_BP    = 20,
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        pixelInc,
  output logic [10:0] hpos,
  output logic [10:0] vpos,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        lineStart,
  output logic        frameStart
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0] frameCnt
`endif
);

  localparam int H_TOTAL = X_MAX + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = Y_MAX + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048) begin : g_h_total_chk
    $error("video_timing_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 2048) begin : g_v_total_chk
    $error("video_timing_gen: V_TOTAL exceeds 2048");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
    $error("video_timing_gen: CLK_DIV must be 1..16");
  end

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FP_START   = 11'(X_MAX);
  localparam logic [10:0] H_SYNC_START = 11'(X_MAX + H_FP);
  localparam logic [10:0] H_BP_START   = 11'(X_MAX + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_FP_START   = 11'(Y_MAX);
  localparam logic [10:0] V_SYNC_START = 11'(Y_MAX + V_FP);
  localparam logic [10:0] V_BP_START   = 11'(Y_MAX + V_FP + V_SYNC);
  localparam logic [3:0]  DIV_LAST     = 4'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_FP,
    ST_SYNC,
    ST_BP
  } phase_e;

  logic [3:0]  div_q, div_d;
  logic [10:0] hpos_q, hpos_d;
  logic [10:0] vpos_q, vpos_d;
  phase_e      hstate_q, hstate_d;
  phase_e      vstate_q, vstate_d;
  logic        pix_q, pix_d;
  logic        line_q, line_d;
  logic        frame_q, frame_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;

  logic        step;
  logic        h_wrap;
  logic [10:0] hpos_nxt;
  logic [10:0] vpos_nxt;
  phase_e      hstate_nxt;
  phase_e      vstate_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      hpos_q   <= H_LAST;
      vpos_q   <= V_LAST;
      hstate_q <= ST_BP;
      vstate_q <= ST_BP;
      pix_q    <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      de_q     <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      hstate_q <= hstate_d;
      vstate_q <= vstate_d;
      pix_q    <= pix_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      de_q     <= de_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  // Position and phase are decoded from the value hpos/vpos take on this
  // strobe, so every output changes on the same edge as the position.
  always_comb begin
    step     = enable && (div_q == DIV_LAST);
    h_wrap   = (hpos_q == H_LAST);
    hpos_nxt = h_wrap ? 11'd0 : hpos_q + 11'd1;
    vpos_nxt = vpos_q;
    if (h_wrap) begin
      vpos_nxt = (vpos_q == V_LAST) ? 11'd0 : vpos_q + 11'd1;
    end

    hstate_nxt = hstate_q;
    case (hstate_q)
      ST_ACTIVE: if (hpos_nxt == H_FP_START) hstate_nxt = (H_FP == 0) ? ST_SYNC : ST_FP;
      ST_FP:     if (hpos_nxt == H_SYNC_START) hstate_nxt = ST_SYNC;
      ST_SYNC:   if (hpos_nxt == H_BP_START) hstate_nxt = ST_BP;
      ST_BP:     if (hpos_nxt == 11'd0) hstate_nxt = ST_ACTIVE;
      default:   hstate_nxt = ST_BP;
    endcase

    vstate_nxt = vstate_q;
    case (vstate_q)
      ST_ACTIVE: if (vpos_nxt == V_FP_START) vstate_nxt = (V_FP == 0) ? ST_SYNC : ST_FP;
      ST_FP:     if (vpos_nxt == V_SYNC_START) vstate_nxt = ST_SYNC;
      ST_SYNC:   if (vpos_nxt == V_BP_START) vstate_nxt = ST_BP;
      ST_BP:     if (vpos_nxt == 11'd0) vstate_nxt = ST_ACTIVE;
      default:   vstate_nxt = ST_BP;
    endcase

    div_d    = div_q;
    hpos_d   = hpos_q;
    vpos_d   = vpos_q;
    hstate_d = hstate_q;
    vstate_d = vstate_q;
    pix_d    = 1'b0;
    line_d   = 1'b0;
    frame_d  = 1'b0;
    de_d     = de_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;

    if (enable) begin
      div_d = step ? 4'd0 : div_q + 4'd1;
    end

    if (step) begin
      hpos_d   = hpos_nxt;
      vpos_d   = vpos_nxt;
      hstate_d = hstate_nxt;
      if (h_wrap) begin
        vstate_d = vstate_nxt;
      end
      pix_d   = 1'b1;
      line_d  = (hpos_nxt == 11'd0);
      frame_d = (hpos_nxt == 11'd0) && (vpos_nxt == 11'd0);
      de_d    = (hstate_d == ST_ACTIVE) && (vstate_d == ST_ACTIVE);
      hsync_d = (hstate_d == ST_SYNC);
      vsync_d = (vstate_d == ST_SYNC);
    end
  end

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  assign frameCnt = frame_cnt_q;
`endif

  assign pixelInc   = pix_q;
  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign de         = de_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign lineStart  = line_q;
  assign frameStart = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed bench for video_timing_gen on small rasters
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, en0, rst1;
  logic        pix0, de0, hs0, vs0, ls0, fs0;
  logic [10:0] h0, v0;
  logic        pix1, de1, hs1, vs1, ls1, fs1;
  logic [10:0] h1, v1;
  logic        pix2, de2, hs2, vs2, ls2, fs2;
  logic [10:0] h2, v2;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] fc0, fc1, fc2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int exp_div;
  int exp_p;
  int exp_fc;

  video_timing_gen #(
    .X_MAX(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .Y_MAX(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(2)
  ) u_dut (
    .clk(clk), .reset(rst0), .enable(en0), .pixelInc(pix0),
    .hpos(h0), .vpos(v0), .de(de0), .hsync(hs0), .vsync(vs0),
    .lineStart(ls0), .frameStart(fs0)
`ifdef VTG_FRAME_CNT_EN
    , .frameCnt(fc0)
`endif
  );

  video_timing_gen #(
    .X_MAX(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .Y_MAX(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(1)
  ) u_div1 (
    .clk(clk), .reset(rst1), .enable(1'b1), .pixelInc(pix1),
    .hpos(h1), .vpos(v1), .de(de1), .hsync(hs1), .vsync(vs1),
    .lineStart(ls1), .frameStart(fs1)
`ifdef VTG_FRAME_CNT_EN
    , .frameCnt(fc1)
`endif
  );

  video_timing_gen #(
    .X_MAX(4), .H_FP(0), .H_SYNC(2), .H_BP(1),
    .Y_MAX(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(1)
  ) u_fp0 (
    .clk(clk), .reset(rst1), .enable(1'b1), .pixelInc(pix2),
    .hpos(h2), .vpos(v2), .de(de2), .hsync(hs2), .vsync(vs2),
    .lineStart(ls2), .frameStart(fs2)
`ifdef VTG_FRAME_CNT_EN
    , .frameCnt(fc2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, edge_n, got, exp);
    end
  endtask

  // Expected raster position for pixel index p (p < 0 is the reset position).
  function automatic int exp_h(input int p);
    return (p < 0) ? 7 : p % 8;
  endfunction

  function automatic int exp_v(input int p);
    return (p < 0) ? 5 : (p / 8) % 6;
  endfunction

  task automatic check_main(input bit strobe);
    int h;
    int v;
    h = exp_h(exp_p);
    v = exp_v(exp_p);
    check("pixelInc", pix0, strobe);
    check("hpos", h0, h);
    check("vpos", v0, v);
    check("de", de0, (h < 4) && (v < 3));
    check("hsync", hs0, (h >= 5) && (h <= 6));
    check("vsync", vs0, v == 4);
    check("lineStart", ls0, strobe && (h == 0));
    check("frameStart", fs0, strobe && (h == 0) && (v == 0));
`ifdef VTG_FRAME_CNT_EN
    check("frameCnt", fc0, exp_fc);
`endif
  endtask

  task automatic tick_main(input bit en);
    bit strobe;
    en0 = en;
    @(posedge clk);
    @(negedge clk);
    edge_n++;
    strobe = 1'b0;
    if (en) begin
      if (exp_div == 1) begin
        exp_div = 0;
        exp_p++;
        strobe = 1'b1;
        if (exp_h(exp_p) == 0 && exp_v(exp_p) == 0) exp_fc = (exp_fc + 1) % 65536;
      end else begin
        exp_div++;
      end
    end
    check_main(strobe);
  endtask

  task automatic reset_main();
    rst0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    edge_n  = 0;
    exp_div = 0;
    exp_p   = -1;
    exp_fc  = 0;
    check_main(1'b0);
    rst0 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    en0  = 1'b1;
    @(negedge clk);

    reset_main();
    for (int i = 0; i < 98; i++) tick_main(1'b1);
    check("frame2_at_98", fs0, 1'b1);

    for (int i = 0; i < 200 && !(exp_p == 50 && exp_div == 1); i++) tick_main(1'b1);
    check("pause_hpos", h0, 2);
    for (int i = 0; i < 5; i++) tick_main(1'b0);
    tick_main(1'b1);
    check("resume_strobe", pix0, 1'b1);
    check("resume_hpos", h0, 3);

    for (int i = 0; i < 200 && exp_p != 86; i++) tick_main(1'b1);
    check("pre_reset_hpos", h0, 6);
    check("pre_reset_vpos", v0, 4);
    reset_main();
    for (int i = 0; i < 4; i++) tick_main(1'b1);

    check("div1_reset_hpos", h1, 7);
    check("fp0_reset_hpos", h2, 6);
    rst1 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      edge_n = k;
      check("div1_pixelInc", pix1, 1'b1);
      check("div1_hpos", h1, (k - 1) % 8);
      check("div1_lineStart", ls1, ((k - 1) % 8) == 0);
      check("fp0_hpos", h2, (k - 1) % 7);
      check("fp0_hsync", hs2, (((k - 1) % 7) >= 4) && (((k - 1) % 7) <= 5));
      check("fp0_de", de2, ((k - 1) % 7) < 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
